matrix_c_reader: RTL and testbench
==================================

Name: matrix_c_reader

Overview:
- Reads the 8x8 product matrix C back out of the result RAM after the multiply controller has filled it.
- Streams C as 64 signed words in row-major order over a valid/ready interface, with row/column tags and a last flag.
- Sits on the RAM read port, opposite the multiply controller's write port, and feeds a downstream checker or host link.
- The result RAM stores element (r,c) at address r + DIM*c (column-major); this block converts that layout to row-major order.

Parameters:
- DATA_W, 19, width of C elements (signed).
- DIM, 8, matrix dimension; power of 2.
- ADDR_W, 6, RAM address width; equals 2*log2(DIM).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  begin readout; sampled only in IDLE.
- mem_addr  out  ADDR_W  result RAM read address.
- mem_re  out  1  read issued this cycle.
- mem_data  in  DATA_W  RAM read data; valid the cycle after the issue cycle.
- out_data  out  DATA_W  streamed C element (signed).
- out_row  out  3  row index of out_data.
- out_col  out  3  column index of out_data.
- out_last  out  1  high with element (DIM-1, DIM-1).
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- busy  out  1  high in PRIME/STREAM.
- done  out  1  one-cycle pulse at completion.

Behaviour:
- Reset (reset_n=0 at posedge):
  - state=IDLE; issue and output counters = 0; 2-entry FIFO emptied; in-flight flag cleared.
  - mem_re=0, out_valid=0, out_last=0, done=0, busy=0; out_data/out_row/out_col=0.
  - Reset mid-stream aborts immediately. No done pulse. Any RAM data returning afterwards is discarded.
- FSM states:
  - IDLE: start=1 -> PRIME.
  - PRIME: one cycle; issues the read of element (0,0) -> STREAM.
  - STREAM: after the 64th output handshake -> DONE.
  - DONE: one cycle; done=1 -> IDLE.
- start is ignored outside IDLE.
- Issue order and addressing:
  - Row-major: index i = 0..63; r = i/DIM, c = i%DIM.
  - mem_addr = r + DIM*c (i=1 -> addr 8; i=8 -> addr 1; i=63 -> addr 63).
- Read issue rule:
  - Issue (mem_re=1) in a cycle only if FIFO occupancy + in-flight reads + 1 <= 2, and fewer than 64 reads have been issued.
  - Occupancy is taken after any same-cycle pop.
  - Data returned one cycle after the issue cycle is pushed at that edge; its r/c tags travel with it.
- Output:
  - out_valid = FIFO non-empty; out_data/out_row/out_col/out_last come from the FIFO head.
  - A handshake (out_valid & out_ready) pops the head.
  - While out_valid=1 and out_ready=0, all outputs hold stable.
  - Simultaneous push and pop is legal; occupancy stays unchanged.
  - The FIFO never overflows; a push into a full FIFO is a design error, flagged by an assertion.
- Latency: start accepted at edge k -> out_valid high after edge k+2.
- Throughput: with out_ready held at 1, one element per cycle; 64 elements in cycles k+2 .. k+65.
- Completion:
  - The handshake of element 63 (out_last=1) moves the FSM to DONE at that edge.
  - done=1 for the next cycle; busy=0 in that same cycle.
- Widths: data is passed through unmodified at DATA_W; no sign extension or truncation.

Optional Feature:
- Macro: MATRIX_C_CHECKSUM_EN.
- Defined:
  - Adds output port checksum, 25 bits, signed.
  - It is the running sum of all handshaken out_data, sign-extended.
  - Cleared on reset and when start is accepted.
  - Final value is stable from the done cycle until the next accepted start.
- Undefined: port and accumulator are absent; all other behaviour is identical.

Test Plan:
- RAM preloaded with mem[a] = a*3-100; out_ready=1; start pulse -> 64 beats in consecutive cycles.
  - Beat 1: row=0, col=1, data=-76 (addr 8).
  - Beat 8: row=1, col=0, data=-97.
  - Beat 63: out_last=1, data=89.
  - done pulses exactly 1 cycle after the last beat.
- Backpressure: same preload, out_ready toggling 1,0,0,1 repeating -> no beat lost or duplicated; outputs stable while stalled; mem_re never issued with 2 entries already committed.
- out_ready=0 for 20 cycles after start -> exactly 2 reads issued; out_valid=1 holding element (0,0)=-100 throughout the stall.
- reset_n=0 for one cycle after beat 30 -> out_valid=0 and busy=0 the next cycle; no done pulse.
  - A new start then replays from (0,0).
- start held high through a whole run, and pulsed while busy -> exactly one 64-beat run per IDLE acceptance; the extra pulse is ignored.
- MATRIX_C_CHECKSUM_EN, all mem=-262144 (DATA_W minimum) -> checksum = -16777216 at done.
  - With all mem=262143 -> checksum = 16777152.

Source files
------------

// File: rtl/matrix_c_reader.sv
// Streams the 8x8 result matrix C out of the column-major result RAM in row-major order.
// Optional running checksum output is enabled with `define MATRIX_C_CHECKSUM_EN.
module matrix_c_reader #(
    parameter int DATA_W = 19,
    parameter int DIM    = 8,
    parameter int ADDR_W = 6
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_re,
    input  logic [DATA_W-1:0]          mem_data,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DIM)-1:0]     out_row,
    output logic [$clog2(DIM)-1:0]     out_col,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       done
`ifdef MATRIX_C_CHECKSUM_EN
    , output logic signed [24:0]       checksum
`endif
);

    localparam int LW = $clog2(DIM);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRIME  = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic [ADDR_W:0]     r_issue_cnt;
    logic                r_inflight;
    logic [LW-1:0]       r_if_row;
    logic [LW-1:0]       r_if_col;
    logic                r_if_last;

    logic [DATA_W-1:0]   r_fd [2];
    logic [LW-1:0]       r_fr [2];
    logic [LW-1:0]       r_fc [2];
    logic                r_fl [2];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_count;

    logic                w_pop;
    logic                w_push;
    logic                w_push_ok;
    logic                w_active;
    logic [1:0]          w_occ_after_pop;
    logic [LW-1:0]       w_issue_row;
    logic [LW-1:0]       w_issue_col;
    logic                w_issue_last;

    assign w_pop           = out_valid && out_ready;
    assign w_push          = r_inflight;
    assign w_push_ok       = w_push && ((r_count != 2'd2) || w_pop);
    assign w_active        = (r_state == S_PRIME) || (r_state == S_STREAM);
    assign w_occ_after_pop = r_count - {1'b0, w_pop};

    // Row-major index i = {row, col}; the RAM holds column-major, so address = {col, row}.
    assign w_issue_row  = r_issue_cnt[ADDR_W-1:LW];
    assign w_issue_col  = r_issue_cnt[LW-1:0];
    assign w_issue_last = (r_issue_cnt[ADDR_W-1:0] == '1);
    assign mem_addr     = {w_issue_col, w_issue_row};

    // A read may only go out when the FIFO can still hold it after everything already committed.
    assign mem_re = w_active && !r_issue_cnt[ADDR_W]
                    && ((w_occ_after_pop + {1'b0, r_inflight}) <= 2'd1);

    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_fd[r_rd_ptr];
    assign out_row   = r_fr[r_rd_ptr];
    assign out_col   = r_fc[r_rd_ptr];
    assign out_last  = r_fl[r_rd_ptr];
    assign busy      = r_busy;
    assign done      = r_done;

`ifdef MATRIX_C_CHECKSUM_EN
    logic signed [24:0] r_checksum;
    logic signed [24:0] w_data_ext;
    assign w_data_ext = {{(25-DATA_W){out_data[DATA_W-1]}}, out_data};
    assign checksum   = r_checksum;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_issue_cnt <= '0;
            r_inflight  <= 1'b0;
            r_if_row    <= '0;
            r_if_col    <= '0;
            r_if_last   <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
            for (int k = 0; k < 2; k++) begin
                r_fd[k] <= '0;
                r_fr[k] <= '0;
                r_fc[k] <= '0;
                r_fl[k] <= 1'b0;
            end
`ifdef MATRIX_C_CHECKSUM_EN
            r_checksum <= '0;
`endif
        end else begin
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_push_ok) begin
                r_fd[r_wr_ptr] <= mem_data;
                r_fr[r_wr_ptr] <= r_if_row;
                r_fc[r_wr_ptr] <= r_if_col;
                r_fl[r_wr_ptr] <= r_if_last;
                r_wr_ptr       <= ~r_wr_ptr;
            end
            r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop};

            // Tags ride alongside the read so they land in the FIFO with its data.
            r_inflight <= mem_re;
            if (mem_re) begin
                r_if_row    <= w_issue_row;
                r_if_col    <= w_issue_col;
                r_if_last   <= w_issue_last;
                r_issue_cnt <= r_issue_cnt + CNT_ONE;
            end
`ifdef MATRIX_C_CHECKSUM_EN
            if (w_pop) begin
                r_checksum <= r_checksum + w_data_ext;
            end
`endif

            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state     <= S_PRIME;
                        r_busy      <= 1'b1;
                        r_issue_cnt <= '0;
`ifdef MATRIX_C_CHECKSUM_EN
                        r_checksum  <= '0;
`endif
                    end
                end
                S_PRIME: begin
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_pop && out_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(w_push && !w_pop && (r_count == 2'd2)));

endmodule

// File: tb/tb_matrix_c_reader.sv
// Directed bench for matrix_c_reader: streaming order, backpressure, stall, abort, start handling.
module tb_matrix_c_reader;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [5:0]        mem_addr;
    logic              mem_re;
    logic [18:0]       mem_data;
    logic [18:0]       out_data;
    logic [2:0]        out_row;
    logic [2:0]        out_col;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
`ifdef MATRIX_C_CHECKSUM_EN
    logic signed [24:0] checksum;
`endif

    logic [18:0] ram [64];
    int          fill_kind;

    int checks   = 0;
    int failures = 0;

    int beats, reads, done_cnt, done_j, first_valid_j, abort_j, last_j;
    logic signed [31:0] exp_csum;
    logic signed [31:0] csum_at_done;

    always #5 clk = ~clk;

    matrix_c_reader #(.DATA_W(19), .DIM(8), .ADDR_W(6)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_data  (mem_data),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
`ifdef MATRIX_C_CHECKSUM_EN
        , .checksum (checksum)
`endif
    );

    // Synchronous-read RAM: data is valid the cycle after the issue cycle.
    always @(posedge clk) begin
        if (mem_re) mem_data <= ram[mem_addr];
    end

    function automatic int exp_val(input int addr);
        if (fill_kind == 1) return -262144;
        if (fill_kind == 2) return 262143;
        return addr * 3 - 100;
    endfunction

    task automatic fill(input int kind);
        fill_kind = kind;
        for (int a = 0; a < 64; a++) ram[a] = 19'(exp_val(a));
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic ready_pat(input int rmode, input int j);
        if (rmode == 1) return (j % 4 == 0) || (j % 4 == 3);
        if (rmode == 2) return (j >= 20);
        return 1'b1;
    endfunction

    // rmode: ready pattern; smode: 0 pulse, 1 hold start until done, 2 extra pulse mid-run.
    task automatic run_stream(input int rmode, input int smode, input int abort_at, input string name);
        logic        rdy;
        logic        prev_stall;
        logic [18:0] s_data;
        logic [2:0]  s_row, s_col;
        logic        s_last;
        int          committed, n, addr;
        beats = 0; reads = 0; done_cnt = 0; done_j = -1; first_valid_j = -1;
        abort_j = -1; last_j = -1; exp_csum = 0; csum_at_done = 0;
        prev_stall = 1'b0;
        s_data = '0; s_row = '0; s_col = '0; s_last = 1'b0;
        start = 1'b1;
        for (int j = 0; j < 400; j++) begin
            @(posedge clk); #1;
            if (smode != 1 && j == 0) start = 1'b0;
            if (smode == 2 && j == 30) start = 1'b1;
            if (smode == 2 && j == 31) start = 1'b0;
            if (reset_n == 1'b0) begin
                chk({name, "_abort_valid"}, out_valid, 0);
                chk({name, "_abort_busy"}, busy, 0);
                reset_n = 1'b1;
            end
            if (first_valid_j < 0 && out_valid) first_valid_j = j;
            if (prev_stall) begin
                chk({name, "_hold_valid"}, out_valid, 1);
                chk({name, "_hold_data"}, $signed(out_data), $signed(s_data));
                chk({name, "_hold_rc"}, {out_row, out_col, out_last}, {s_row, s_col, s_last});
            end
            if (rmode == 2 && j >= 2 && j < 20) begin
                chk({name, "_stall_valid"}, out_valid, 1);
                chk({name, "_stall_data"}, $signed(out_data), -100);
            end
            if (rmode == 2 && j == 20) chk({name, "_stall_reads"}, reads, 2);
            if (done) begin
                done_cnt++;
                done_j = j;
                chk({name, "_busy_at_done"}, busy, 0);
`ifdef MATRIX_C_CHECKSUM_EN
                csum_at_done = checksum;
                chk({name, "_csum_done"}, checksum, exp_csum);
`endif
                if (smode == 1) start = 1'b0;
            end
`ifdef MATRIX_C_CHECKSUM_EN
            if (done_j >= 0 && j == done_j + 5) chk({name, "_csum_hold"}, checksum, exp_csum);
`endif
            rdy = ready_pat(rmode, j);
            out_ready = rdy;
            #1;
            if (mem_re) begin
                committed = reads - beats - ((out_valid && rdy) ? 1 : 0);
                chk({name, "_issue_room"}, (committed <= 1), 1);
                reads++;
            end
            if (out_valid && rdy) begin
                n = beats;
                addr = n / 8 + 8 * (n % 8);
                chk({name, "_row"}, out_row, n / 8);
                chk({name, "_col"}, out_col, n % 8);
                chk({name, "_data"}, $signed(out_data), exp_val(addr));
                chk({name, "_last"}, out_last, (n == 63) ? 1 : 0);
                exp_csum = exp_csum + exp_val(addr);
                if (n == 63) last_j = j;
                beats++;
                if (abort_at > 0 && beats == abort_at) begin
                    reset_n = 1'b0;
                    abort_j = j;
                end
            end
            prev_stall = out_valid && !rdy;
            s_data = out_data; s_row = out_row; s_col = out_col; s_last = out_last;
            if (done_j >= 0 && j >= done_j + 12) break;
            if (abort_j >= 0 && j >= abort_j + 12) break;
        end
        start = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic post_full(input string name);
        chk({name, "_beats"}, beats, 64);
        chk({name, "_reads"}, reads, 64);
        chk({name, "_done_cnt"}, done_cnt, 1);
        chk({name, "_done_after_last"}, done_j, last_j + 1);
        chk({name, "_idle_busy"}, busy, 0);
        chk({name, "_idle_valid"}, out_valid, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        fill(0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_re", mem_re, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", $signed(out_data), 0);
        chk("rst_row", out_row, 0);
        chk("rst_col", out_col, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_stream(0, 0, 0, "base");
        post_full("base");
        chk("base_first_valid", first_valid_j, 2);
        chk("base_done_j", done_j, 66);

        run_stream(1, 0, 0, "bp");
        post_full("bp");

        run_stream(2, 0, 0, "stall");
        post_full("stall");

        run_stream(0, 0, 31, "abort");
        chk("abort_done_cnt", done_cnt, 0);
        chk("abort_beats", beats, 31);
        chk("abort_end_valid", out_valid, 0);
        chk("abort_end_busy", busy, 0);

        run_stream(0, 0, 0, "replay");
        post_full("replay");
        chk("replay_first_valid", first_valid_j, 2);

        run_stream(0, 1, 0, "hold");
        post_full("hold");

        run_stream(0, 2, 0, "pulse");
        post_full("pulse");

`ifdef MATRIX_C_CHECKSUM_EN
        fill(1);
        run_stream(0, 0, 0, "csum_min");
        post_full("csum_min");
        chk("csum_min_value", csum_at_done, -16777216);
        fill(2);
        run_stream(0, 0, 0, "csum_max");
        post_full("csum_max");
        chk("csum_max_value", csum_at_done, 16777152);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
